// File: rtl/video_colorizer_ntsc.sv
// Apple II serial video to VGA colour: NTSC artifact-colour decode, mono tints,
// and regenerated sync/blanking, all on the 14.318 MHz master clock.
module video_colorizer_ntsc #(
    parameter int unsigned COLOR_BITS  = 8,
    parameter int unsigned HCOUNT_BITS = 11,
    parameter int unsigned HS_START    = 694,
    parameter int unsigned HS_WIDTH    = 68,
    parameter int unsigned VS_LINE     = 33,
    parameter int unsigned VS_LINES    = 3,
    parameter int unsigned DE_DEPTH    = 18,
    parameter int unsigned DE_TAP_A    = 9,
    parameter int unsigned DE_TAP_B    = 17
) (
    input  logic                      i_clk_14m,
    input  logic                      i_reset,
    input  logic                      i_video,
    input  logic                      i_color_line,
    input  logic [1:0]                i_screen_mode,
    input  logic                      i_hbl,
    input  logic                      i_vbl,
    input  logic                      i_pal_we,
    input  logic [1:0]                i_pal_addr,
    input  logic [3*COLOR_BITS-1:0]   i_pal_data,
    output logic                      o_vga_hs,
    output logic                      o_vga_vs,
    output logic                      o_vga_hbl,
    output logic                      o_vga_vbl,
    output logic [COLOR_BITS-1:0]     o_vga_r,
    output logic [COLOR_BITS-1:0]     o_vga_g,
    output logic [COLOR_BITS-1:0]     o_vga_b
);

    localparam int unsigned SUM_W = COLOR_BITS + 2;
    localparam int unsigned VC_W  = 6;
    localparam int unsigned SR_W  = 6;

    localparam logic [3:0][7:0] PAL_R_DEF = {8'h70, 8'h08, 8'h37, 8'h50};
    localparam logic [3:0][7:0] PAL_G_DEF = {8'h07, 8'h2C, 8'h94, 8'h38};
    localparam logic [3:0][7:0] PAL_B_DEF = {8'h07, 8'hB0, 8'h10, 8'h38};

    localparam logic [COLOR_BITS-1:0] PIX_MID = {1'b1, {(COLOR_BITS-1){1'b0}}};

    localparam logic [HCOUNT_BITS-1:0] HC_HS_SET = HCOUNT_BITS'(HS_START);
    localparam logic [HCOUNT_BITS-1:0] HC_HS_CLR = HCOUNT_BITS'(HS_START + HS_WIDTH);
    localparam logic [VC_W-1:0]        VC_VS_SET = VC_W'(VS_LINE);
    localparam logic [VC_W-1:0]        VC_VS_CLR = VC_W'(VS_LINE + VS_LINES);

    logic [HCOUNT_BITS-1:0]      r_hcount;
    logic [VC_W-1:0]             r_vcount;
    logic                        r_last_hbl;
    logic                        r_line_mode;
    logic [SR_W-1:0]             r_sr;
    logic [DE_DEPTH-1:0]         r_de;
    logic [3:0][COLOR_BITS-1:0]  r_pal_r;
    logic [3:0][COLOR_BITS-1:0]  r_pal_g;
    logic [3:0][COLOR_BITS-1:0]  r_pal_b;
    logic                        r_vga_hs;
    logic                        r_vga_vs;
    logic                        r_vga_hbl;
    logic                        r_vga_vbl;
    logic [COLOR_BITS-1:0]       r_vga_r;
    logic [COLOR_BITS-1:0]       r_vga_g;
    logic [COLOR_BITS-1:0]       r_vga_b;

    logic                        w_line_start;
    logic [1:0]                  w_phase;
    logic                        w_stable;
    logic                        w_mono_sel;
    logic [23:0]                 w_mono;
    logic [COLOR_BITS-1:0]       w_pix_r;
    logic [COLOR_BITS-1:0]       w_pix_g;
    logic [COLOR_BITS-1:0]       w_pix_b;

    // Keep the most significant COLOR_BITS of an 8-bit colour constant.
    function automatic logic [COLOR_BITS-1:0] trunc8(input logic [7:0] v);
        return v[7 -: COLOR_BITS];
    endfunction

    function automatic logic [23:0] mono_rgb(input logic [1:0] mode, input logic fg);
        logic [23:0] rgb;
        case (mode)
            2'b10:   rgb = fg ? 24'h00C001 : 24'h000F01;
            2'b11:   rgb = fg ? 24'hFF8001 : 24'h200801;
            default: rgb = fg ? 24'hFFFFFF : 24'h000000;
        endcase
        return rgb;
    endfunction

    // Artifact colour: each lit bit in the window adds the palette entry for its phase.
    function automatic logic [COLOR_BITS-1:0] chan_sum(
        input logic [3:0][COLOR_BITS-1:0] pal,
        input logic [SR_W-1:0]            sr,
        input logic [1:0]                 p
    );
        logic [SUM_W-1:0] acc;
        logic [1:0]       p1;
        logic [1:0]       p2;
        logic [1:0]       p3;
        p1  = p + 2'd1;
        p2  = p + 2'd2;
        p3  = p + 2'd3;
        acc = '0;
        if (sr[1]) acc = acc + SUM_W'(pal[p1]);
        if (sr[2]) acc = acc + SUM_W'(pal[p2]);
        if (sr[3]) acc = acc + SUM_W'(pal[p3]);
        if (sr[4]) acc = acc + SUM_W'(pal[p]);
        if (|acc[SUM_W-1 -: 2]) begin
            return '1;
        end
        return acc[COLOR_BITS-1:0];
    endfunction

    assign w_line_start = r_last_hbl & ~i_hbl;
    assign w_phase      = r_hcount[1:0];
    assign w_stable     = (r_sr[0] == r_sr[4]) && (r_sr[1] == r_sr[5]);
    assign w_mono_sel   = r_line_mode || (i_screen_mode != 2'b00);
    assign w_mono       = mono_rgb(i_screen_mode, r_sr[2]);

    always_comb begin
        w_pix_r = '0;
        w_pix_g = '0;
        w_pix_b = '0;
        if (w_mono_sel) begin
            w_pix_r = w_mono[23 -: COLOR_BITS];
            w_pix_g = w_mono[15 -: COLOR_BITS];
            w_pix_b = w_mono[7 -: COLOR_BITS];
        end else if (w_stable) begin
            w_pix_r = chan_sum(r_pal_r, r_sr, w_phase);
            w_pix_g = chan_sum(r_pal_g, r_sr, w_phase);
            w_pix_b = chan_sum(r_pal_b, r_sr, w_phase);
        end else begin
            // Colour burst edges: fall back to a luminance-only estimate.
            case (r_sr[3:2])
                2'b11: begin
                    w_pix_r = '1;
                    w_pix_g = '1;
                    w_pix_b = '1;
                end
                2'b00: begin
                    w_pix_r = '0;
                    w_pix_g = '0;
                    w_pix_b = '0;
                end
                default: begin
                    w_pix_r = PIX_MID;
                    w_pix_g = PIX_MID;
                    w_pix_b = PIX_MID;
                end
            endcase
        end
    end

    // Line timing: counters, line mode latch and blanking history.
    always_ff @(posedge i_clk_14m) begin
        if (i_reset) begin
            r_hcount    <= '0;
            r_vcount    <= '0;
            r_last_hbl  <= 1'b0;
            r_line_mode <= 1'b0;
            r_de        <= '0;
            r_vga_vbl   <= 1'b0;
        end else begin
            r_last_hbl <= i_hbl;
            r_de       <= {r_de[DE_DEPTH-2:0], r_last_hbl};
            if (w_line_start) begin
                r_hcount    <= '0;
                r_line_mode <= i_color_line;
                r_vga_vbl   <= i_vbl;
                if (!i_vbl) begin
                    r_vcount <= '0;
                end else if (r_vcount != '1) begin
                    r_vcount <= r_vcount + VC_W'(1);
                end
            end else if (r_hcount != '1) begin
                r_hcount <= r_hcount + HCOUNT_BITS'(1);
            end
        end
    end

    // Sync generation and delayed horizontal blanking.
    always_ff @(posedge i_clk_14m) begin
        if (i_reset) begin
            r_vga_hs  <= 1'b0;
            r_vga_vs  <= 1'b0;
            r_vga_hbl <= 1'b0;
        end else begin
            r_vga_hbl <= r_de[DE_TAP_A] & r_de[DE_TAP_B];
            if (r_hcount == HC_HS_SET) begin
                r_vga_hs <= 1'b1;
                if (r_vcount == VC_VS_SET) begin
                    r_vga_vs <= 1'b1;
                end else if (r_vcount == VC_VS_CLR) begin
                    r_vga_vs <= 1'b0;
                end
            end else if (r_hcount == HC_HS_CLR) begin
                r_vga_hs <= 1'b0;
            end
        end
    end

    // Pixel pipeline: serial window and registered colour.
    always_ff @(posedge i_clk_14m) begin
        if (i_reset) begin
            r_sr    <= '0;
            r_vga_r <= '0;
            r_vga_g <= '0;
            r_vga_b <= '0;
        end else begin
            r_sr    <= {i_video, r_sr[SR_W-1:1]};
            r_vga_r <= w_pix_r;
            r_vga_g <= w_pix_g;
            r_vga_b <= w_pix_b;
        end
    end

    // Phase palette; a write lands at the edge, so that cycle's pixel sees the old entry.
    always_ff @(posedge i_clk_14m) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) begin
                r_pal_r[i] <= trunc8(PAL_R_DEF[i]);
                r_pal_g[i] <= trunc8(PAL_G_DEF[i]);
                r_pal_b[i] <= trunc8(PAL_B_DEF[i]);
            end
        end else if (i_pal_we) begin
            r_pal_r[i_pal_addr] <= i_pal_data[3*COLOR_BITS-1 -: COLOR_BITS];
            r_pal_g[i_pal_addr] <= i_pal_data[2*COLOR_BITS-1 -: COLOR_BITS];
            r_pal_b[i_pal_addr] <= i_pal_data[COLOR_BITS-1:0];
        end
    end

    assign o_vga_hs  = r_vga_hs;
    assign o_vga_vs  = r_vga_vs;
    assign o_vga_hbl = r_vga_hbl;
    assign o_vga_vbl = r_vga_vbl;
    assign o_vga_r   = r_vga_r;
    assign o_vga_g   = r_vga_g;
    assign o_vga_b   = r_vga_b;

endmodule
